// File: rtl/core_pkg.sv
// Shared types and constants for the retire/commit path.
// Slot i of every flattened retire bus lives at bits [i*W +: W].
package core_pkg;

    localparam int RET_W        = 3;
    localparam int PREG_W       = 5;
    localparam int AREG_W       = 3;
    localparam int NUM_AREG     = 8;
    localparam int FLUSH_CYCLES = 2;

    localparam logic [1:0] TYPE_NODEST = 2'b11;

    typedef struct packed {
        logic              ready;
        logic              excep;
        logic [1:0]        Type;
        logic [PREG_W-1:0] Pw;
        logic [PREG_W-1:0] Pw_old;
        logic [AREG_W-1:0] Rw;
    } retire_slot_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } commit_state_t;

    function automatic logic [1:0] count_commits(input logic [RET_W-1:0] mask);
        return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
    endfunction

endpackage

// File: rtl/arat_regfile.sv
// Architectural RAT: 8 x 5 flops, identity reset, three write ports where the
// highest-numbered port wins on an address collision.
module arat_regfile
    import core_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RET_W-1:0]           we,
    input  logic [RET_W*AREG_W-1:0]    waddr,
    input  logic [RET_W*PREG_W-1:0]    wdata,
    output logic [NUM_AREG*PREG_W-1:0] rdata
);

    logic [PREG_W-1:0] map_r [NUM_AREG];

    // Later loop iterations override earlier ones, giving slot-order priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < NUM_AREG; a++) begin
                map_r[a] <= PREG_W'(a);
            end
        end else begin
            for (int s = 0; s < RET_W; s++) begin
                if (we[s]) begin
                    map_r[waddr[s*AREG_W +: AREG_W]] <= wdata[s*PREG_W +: PREG_W];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int a = 0; a < NUM_AREG; a++) begin
            rdata[a*PREG_W +: PREG_W] = map_r[a];
        end
    end

endmodule

// File: rtl/commit_unit.sv
// Retire-side consumer of the ROB: commits up to three head entries per cycle
// into the ARAT, frees superseded pregs and runs the exception flush/recover.
module commit_unit
    import core_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RET_W-1:0]           ready_ret,
    input  logic [RET_W-1:0]           excep_ret,
    input  logic [RET_W*2-1:0]         Type_ret,
    input  logic [RET_W*PREG_W-1:0]    Pw_ret,
    input  logic [RET_W*PREG_W-1:0]    Pw_old_ret,
    input  logic [RET_W*AREG_W-1:0]    Rw_ret,
    output logic [RET_W-1:0]           free_valid,
    output logic [RET_W*PREG_W-1:0]    free_preg,
    output logic [1:0]                 retire_cnt,
    output logic [31:0]                instret,
    output logic                       flush,
    output logic                       recover_valid,
    output logic [NUM_AREG*PREG_W-1:0] arat_map,
    output logic [AREG_W-1:0]          excep_rw
);

    retire_slot_t              slot_s [RET_W];
    logic [RET_W-1:0]          ok_s;
    logic [RET_W-1:0]          commit_s;
    logic [RET_W-1:0]          we_s;
    logic                      excep_hit_s;
    logic [AREG_W-1:0]         excep_slot_rw_s;
    commit_state_t             state_r, next_state_s;
    logic [1:0]                flush_cnt_r, next_cnt_s;
    logic [RET_W*PREG_W-1:0]   free_preg_next_s;
    logic [AREG_W-1:0]         excep_rw_next_s;

    always_comb begin
        for (int i = 0; i < RET_W; i++) begin
            slot_s[i].ready  = ready_ret[i];
            slot_s[i].excep  = excep_ret[i];
            slot_s[i].Type   = Type_ret[i*2 +: 2];
            slot_s[i].Pw     = Pw_ret[i*PREG_W +: PREG_W];
            slot_s[i].Pw_old = Pw_old_ret[i*PREG_W +: PREG_W];
            slot_s[i].Rw     = Rw_ret[i*AREG_W +: AREG_W];
        end
    end

    // Prefix commit mask; the first non-ok slot is the exception candidate.
    always_comb begin
        for (int i = 0; i < RET_W; i++) begin
            ok_s[i] = slot_s[i].ready & ~slot_s[i].excep;
        end
        commit_s[0] = (state_r == RUN) & ok_s[0];
        commit_s[1] = commit_s[0] & ok_s[1];
        commit_s[2] = commit_s[1] & ok_s[2];
        for (int i = 0; i < RET_W; i++) begin
            we_s[i] = commit_s[i] & (slot_s[i].Type != TYPE_NODEST);
        end
        excep_hit_s     = 1'b0;
        excep_slot_rw_s = 3'd0;
        if ((state_r == RUN) && slot_s[0].ready && slot_s[0].excep) begin
            excep_hit_s     = 1'b1;
            excep_slot_rw_s = slot_s[0].Rw;
        end else if (commit_s[0] && slot_s[1].ready && slot_s[1].excep) begin
            excep_hit_s     = 1'b1;
            excep_slot_rw_s = slot_s[1].Rw;
        end else if (commit_s[1] && slot_s[2].ready && slot_s[2].excep) begin
            excep_hit_s     = 1'b1;
            excep_slot_rw_s = slot_s[2].Rw;
        end else begin
            excep_hit_s     = 1'b0;
        end
    end

    arat_regfile u_arat (
        .clk   (clk),
        .rst   (rst),
        .we    (we_s),
        .waddr (Rw_ret),
        .wdata (Pw_ret),
        .rdata (arat_map)
    );

    // FSM state register with the flush down-counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= RUN;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= next_state_s;
            flush_cnt_r <= next_cnt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = flush_cnt_r;
        case (state_r)
            RUN: begin
                if (excep_hit_s) begin
                    next_state_s = FLUSH;
                    next_cnt_s   = 2'(FLUSH_CYCLES - 1);
                end else begin
                    next_state_s = RUN;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == 2'd0) begin
                    next_state_s = RECOVER;
                end else begin
                    next_cnt_s   = flush_cnt_r - 2'd1;
                end
            end
            RECOVER: next_state_s = RUN;
            default: next_state_s = RUN;
        endcase
    end

    // Next values for the registered outputs.
    always_comb begin
        free_preg_next_s = '0;
        for (int i = 0; i < RET_W; i++) begin
            if (we_s[i]) begin
                free_preg_next_s[i*PREG_W +: PREG_W] = slot_s[i].Pw_old;
            end else begin
                free_preg_next_s[i*PREG_W +: PREG_W] = 5'd0;
            end
        end
        if (excep_hit_s) begin
            excep_rw_next_s = excep_slot_rw_s;
        end else begin
            excep_rw_next_s = excep_rw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            free_valid    <= 3'b000;
            free_preg     <= '0;
            retire_cnt    <= 2'd0;
            instret       <= 32'd0;
            flush         <= 1'b0;
            recover_valid <= 1'b0;
            excep_rw      <= 3'd0;
        end else begin
            free_valid    <= we_s;
            free_preg     <= free_preg_next_s;
            retire_cnt    <= count_commits(commit_s);
            instret       <= instret + {30'd0, count_commits(commit_s)};
            flush         <= (next_state_s == FLUSH);
            recover_valid <= (next_state_s == RECOVER);
            excep_rw      <= excep_rw_next_s;
        end
    end

endmodule
